counter_0_to_9: RTL and testbench



---
 rtl/counter_pkg.sv | 9 +
 rtl/counter_0_to_9.sv | 58 +++++
 tb/tb_counter_0_to_9.sv | 120 ++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants and count type for the decimal digit counter.
package counter_pkg;

  localparam int unsigned COUNT_WIDTH = 4;
  localparam int unsigned COUNT_MAX   = 9;

  typedef logic [COUNT_WIDTH-1:0] count_t;

endpackage : counter_pkg

// File: rtl/counter_0_to_9.sv
// Mod-(MAX_VAL+1) up-counter with count enable and asynchronous active-high reset.
// Define COUNTER_0_TO_9_SVA_EN to compile the embedded concurrent assertions.
//
// Handshake: en acts as a one-cycle "advance" strobe with no back-pressure;
// each rising clk edge that samples en=1 moves cnt one step, visible after that edge.
module counter_0_to_9
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = COUNT_WIDTH,
  parameter int unsigned MAX_VAL = COUNT_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic [WIDTH-1:0] cnt_next;

  // Any value at or above the terminal count (including upset states) wraps to zero.
  always_comb begin
    cnt_next = cnt;
    if (en) begin
      if (cnt >= MAX_V) begin
        cnt_next = '0;
      end else begin
        cnt_next = cnt + ONE_V;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

`ifdef COUNTER_0_TO_9_SVA_EN
  a_cnt_range: assert property (@(posedge clk) disable iff (rst) cnt <= MAX_V)
    else $error("[%0t] cnt out of range: cnt=%0d", $time, cnt);

  a_hold: assert property (@(posedge clk) disable iff (rst) !en |=> cnt == $past(cnt))
    else $error("[%0t] cnt changed while en low: cnt=%0d", $time, cnt);

  a_wrap: assert property (@(posedge clk) disable iff (rst) (en && cnt == MAX_V) |=> cnt == '0)
    else $error("[%0t] cnt did not wrap to 0: cnt=%0d", $time, cnt);

  a_incr: assert property (@(posedge clk) disable iff (rst)
                           (en && cnt < MAX_V) |=> cnt == $past(cnt) + ONE_V)
    else $error("[%0t] cnt did not increment: cnt=%0d", $time, cnt);
`endif

endmodule : counter_0_to_9

// File: tb/tb_counter_0_to_9.sv
// Scoreboard bench for counter_0_to_9: directed plan followed by randomized en/rst traffic.
module tb_counter_0_to_9;

  localparam int W   = 4;
  localparam int MAX = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic [W-1:0] cnt;

  logic [W-1:0] exp_q[$];
  int           model = 0;
  int           n_checks = 0;
  int           n_pass = 0;

  counter_0_to_9 #(.WIDTH(W), .MAX_VAL(MAX)) dut (
    .clk(clk),
    .rst(rst),
    .en (en),
    .cnt(cnt)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [W-1:0] act,
                                input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endfunction

  // Reference: a decimal digit advancing by one, anything outside 0..MAX restarts at 0.
  function automatic int next_digit(input int cur, input bit rst_v, input bit en_v);
    if (rst_v) return 0;
    if (!en_v) return cur;
    if (cur > MAX) return 0;
    return (cur + 1) % (MAX + 1);
  endfunction

  // Driver: set inputs on the falling edge and queue the value due after the next rising edge.
  task automatic tick(input bit en_v, input bit rst_v);
    @(negedge clk);
    en  = en_v;
    rst = rst_v;
    model = next_digit(model, rst_v, en_v);
    exp_q.push_back(W'(model));
  endtask

  // Monitor: compare each rising-edge result against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("cnt_seq", cnt, e);
    end
  end

  initial begin
    // Power-up reset, asserted between edges with en high.
    en = 1'b1;
    #1 rst = 1'b1;
    #1 check("por_async", cnt, '0);
    model = 0;
    tick(1, 1);
    tick(1, 1);

    // Release and count through one wrap: 1..9,0,1,2.
    for (int i = 0; i < 12; i++) tick(1, 0);

    // Advance to 4, hold for 15 edges, resume.
    tick(1, 0);
    tick(1, 0);
    for (int i = 0; i < 15; i++) tick(0, 0);
    tick(1, 0);

    // Reach 7, then assert reset mid-cycle.
    tick(1, 0);
    tick(1, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("mid_async_rst", cnt, '0);
    model = 0;
    for (int i = 0; i < 3; i++) tick(1, 1);
    tick(1, 0);

    // Plant an illegal value; the next enabled edge must restore 0.
    @(negedge clk);
    en = 1'b0;
    force dut.cnt = 4'd12;
    #1 release dut.cnt;
    #1 check("illegal_plant", cnt, 4'd12);
    model = 12;
    tick(1, 0);

    // Reach 9, stall there with en low, then wrap.
    for (int i = 0; i < 9; i++) tick(1, 0);
    for (int i = 0; i < 3; i++) tick(0, 0);
    tick(1, 0);

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      tick(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end
    tick(0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_counter_0_to_9
